// File: rtl/divider_multi.sv
// divider_multi
//   Parametrised Start/Ack unsigned divider. The division algorithm is chosen
//   at elaboration time:
//     MODE 0 - repeated subtraction, STEPS conditional subtractions per clock
//     MODE 1 - restoring shift-subtract, STEPS quotient bits per clock
//   A divisor of zero is flagged at Start, and the unit goes straight to DONE_S.
//   SCEN gates every COMPUTE clock, so a division can be single-stepped from a
//   board button. Cycles counts the enabled COMPUTE clocks of the current or
//   last division.
//
// Ports
//   Clk        clock; all state changes on the rising edge
//   Reset      asynchronous, active-high reset
//   Xin, Yin   dividend and divisor (unsigned, WIDTH bits)
//   Start      begin a division (sampled in INITIAL)
//   Ack        acknowledge the result (sampled in DONE_S)
//   SCEN       single-cycle enable; COMPUTE advances only while high
//   Done       high in DONE_S
//   DivZero    Yin was zero at Start
//   Quotient   quotient register
//   Remainder  remainder register; during COMPUTE it shows the working remainder
//   Cycles     enabled COMPUTE clocks, saturating at 2^CNT_W-1
//   Qi/Qc/Qd   one-hot state bits for INITIAL / COMPUTE / DONE_S

module divider_multi #(
  parameter int WIDTH = 8,
  parameter int STEPS = 2,
  parameter int MODE  = 0,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Xin,
  input  logic [WIDTH-1:0] Yin,
  input  logic             Start,
  input  logic             Ack,
  input  logic             SCEN,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic [CNT_W-1:0] Cycles,
  output logic             Qi,
  output logic             Qc,
  output logic             Qd
);

  localparam int IDX_W = $clog2(WIDTH + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH);
  localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(STEPS);

  typedef enum logic [2:0] {
    INITIAL = 3'b001,
    COMPUTE = 3'b010,
    DONE_S  = 3'b100
  } state_t;

  state_t state;

  // x: working dividend (MODE 0) or dividend shift register (MODE 1)
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  // Partial remainder for MODE 1; one extra bit because the shifted value
  // can reach 2*y-1 before the trial subtraction.
  logic [WIDTH:0]   p;
  logic [IDX_W-1:0] bit_idx;

  logic [WIDTH-1:0] m0_x, m0_q;
  logic [WIDTH-1:0] m1_x, m1_q;
  logic [WIDTH:0]   m1_p;
  logic [IDX_W-1:0] bit_next;

  logic [WIDTH-1:0] next_x;
  logic [WIDTH-1:0] next_q;
  logic [WIDTH-1:0] next_rem;
  logic             next_last;

  assign {Qd, Qc, Qi} = state;
  assign Done         = (state == DONE_S);

  // One clock's worth of chained steps for both algorithms; MODE picks which
  // result the registers take.
  always_comb begin
    m0_x = x;
    m0_q = Quotient;
    for (int s = 0; s < STEPS; s++) begin
      if (m0_x >= y) begin
        m0_x = m0_x - y;
        m0_q = m0_q + WIDTH'(1);
      end
    end

    m1_x = x;
    m1_q = Quotient;
    m1_p = p;
    for (int s = 0; s < STEPS; s++) begin
      m1_p = {m1_p[WIDTH-1:0], m1_x[WIDTH-1]};
      m1_x = m1_x << 1;
      if (m1_p >= {1'b0, y}) begin
        m1_p = m1_p - {1'b0, y};
        m1_q = {m1_q[WIDTH-2:0], 1'b1};
      end else begin
        m1_q = {m1_q[WIDTH-2:0], 1'b0};
      end
    end
    bit_next = bit_idx + IDX_STEP;

    if (MODE == 0) begin
      next_x    = m0_x;
      next_q    = m0_q;
      next_rem  = m0_x;
      next_last = (m0_x < y);
    end else begin
      next_x    = m1_x;
      next_q    = m1_q;
      next_rem  = m1_p[WIDTH-1:0];
      next_last = (bit_next == IDX_LAST);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= INITIAL;
      x         <= '0;
      y         <= '0;
      p         <= '0;
      bit_idx   <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      Cycles    <= '0;
      DivZero   <= 1'b0;
    end else begin
      case (state)
        INITIAL: begin
          x        <= Xin;
          y        <= Yin;
          p        <= '0;
          bit_idx  <= '0;
          Quotient <= '0;
          Cycles   <= '0;
          DivZero  <= 1'b0;
          if (Start) begin
            if (Yin == '0) begin
              // Divide by zero finishes at once with a saturated quotient.
              state     <= DONE_S;
              DivZero   <= 1'b1;
              Quotient  <= '1;
              Remainder <= Xin;
            end else begin
              state <= COMPUTE;
            end
          end
        end

        COMPUTE: begin
          if (SCEN) begin
            if (Cycles != '1) begin
              Cycles <= Cycles + CNT_W'(1);
            end
            x         <= next_x;
            p         <= m1_p;
            bit_idx   <= bit_next;
            Quotient  <= next_q;
            Remainder <= next_rem;
            if (next_last) begin
              state <= DONE_S;
            end
          end
        end

        DONE_S: begin
          if (Ack) begin
            state <= INITIAL;
          end
        end

        default: state <= INITIAL;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_multi.sv
// tb_divider_multi
//   Self-checking bench for divider_multi. One repeated-subtraction instance
//   and one shift-subtract instance (WIDTH 8, STEPS 2) share every input, so
//   each division is checked in both algorithms at once. Expected results come
//   from a table of hand-worked vectors and from an arithmetic reference model
//   (X/Y, X%Y, clock-count formulas) for random operands.

module tb_divider_multi;

  localparam int WIDTH = 8;
  localparam int STEPS = 2;
  localparam int CNT_W = 16;
  localparam int LIMIT = 1000;

  logic             Clk;
  logic             Reset;
  logic [WIDTH-1:0] Xin;
  logic [WIDTH-1:0] Yin;
  logic             Start;
  logic             Ack;
  logic             SCEN;

  logic             done0, dz0, qi0, qc0, qd0;
  logic [WIDTH-1:0] q0, r0;
  logic [CNT_W-1:0] cyc0;
  logic             done1, dz1, qi1, qc1, qd1;
  logic [WIDTH-1:0] q1, r1;
  logic [CNT_W-1:0] cyc1;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int x;
    int y;
    int q;
    int r;
    int cyc0;
    int cyc1;
    int dz;
  } vec_t;

  vec_t table_v[9];

  divider_multi #(.WIDTH(WIDTH), .STEPS(STEPS), .MODE(0), .CNT_W(CNT_W)) dut0 (
    .Clk(Clk), .Reset(Reset), .Xin(Xin), .Yin(Yin), .Start(Start), .Ack(Ack),
    .SCEN(SCEN), .Done(done0), .DivZero(dz0), .Quotient(q0), .Remainder(r0),
    .Cycles(cyc0), .Qi(qi0), .Qc(qc0), .Qd(qd0)
  );

  divider_multi #(.WIDTH(WIDTH), .STEPS(STEPS), .MODE(1), .CNT_W(CNT_W)) dut1 (
    .Clk(Clk), .Reset(Reset), .Xin(Xin), .Yin(Yin), .Start(Start), .Ack(Ack),
    .SCEN(SCEN), .Done(done1), .DivZero(dz1), .Quotient(q1), .Remainder(r1),
    .Cycles(cyc1), .Qi(qi1), .Qc(qc1), .Qd(qd1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference results straight from the arithmetic definition of division.
  function automatic void model(input int x, input int y, output int q,
                                output int r, output int c0, output int c1,
                                output int dz);
    if (y == 0) begin
      q  = (1 << WIDTH) - 1;
      r  = x;
      c0 = 0;
      c1 = 0;
      dz = 1;
    end else begin
      q  = x / y;
      r  = x % y;
      c0 = (q == 0) ? 1 : (q + STEPS - 1) / STEPS;
      c1 = WIDTH / STEPS;
      dz = 0;
    end
  endfunction

  // Drives SCEN each clock until both units are done. While the MODE 0 unit
  // computes, its progress is checked: after k enabled clocks the quotient is
  // min(k*STEPS, X/Y). scen_mode: 0 always on, 1 one clock in three, 2 random.
  task automatic runCompute(input int x, input int y, input int scen_mode,
                            output int clk0, output int clk1, output int en0);
    int n;
    int qf;
    int qexp;
    clk0 = 0;
    clk1 = 0;
    en0  = 0;
    n    = 0;
    qf   = (y == 0) ? 0 : x / y;
    while (!(done0 && done1) && n < LIMIT) begin
      if (qc0) begin
        qexp = en0 * STEPS;
        if (qexp > qf) qexp = qf;
        checkOutput("inflight_q_m0", q0, qexp);
        checkOutput("inflight_cycles_m0", cyc0, en0);
        if (en0 > 0) checkOutput("inflight_rem_m0", r0, x - qexp * y);
        clk0++;
      end
      if (qc1) clk1++;
      if (scen_mode == 0)      SCEN = 1'b1;
      else if (scen_mode == 1) SCEN = (n % 3 == 2);
      else                     SCEN = 1'($urandom_range(0, 1));
      if (qc0 && SCEN) en0++;
      @(negedge Clk);
      n++;
    end
    checkOutput("done_reached", done0 && done1, 1);
  endtask

  task automatic applyStimulus(input int x, input int y, input int scen_mode,
                               output int clk0, output int clk1, output int en0);
    @(negedge Clk);
    Xin   = x[WIDTH-1:0];
    Yin   = y[WIDTH-1:0];
    Start = 1'b1;
    Ack   = 1'b0;
    @(negedge Clk);
    Start = 1'b0;
    runCompute(x, y, scen_mode, clk0, clk1, en0);
  endtask

  task automatic checkResult(input int q, input int r, input int c0, input int c1,
                             input int dz, input int clk0, input int clk1,
                             input bit check_clocks);
    checkOutput("quotient_m0", q0, q);
    checkOutput("remainder_m0", r0, r);
    checkOutput("cycles_m0", cyc0, c0);
    checkOutput("divzero_m0", dz0, dz);
    checkOutput("qd_m0", {done0, qd0, qc0, qi0}, 4'b1100);
    checkOutput("quotient_m1", q1, q);
    checkOutput("remainder_m1", r1, r);
    checkOutput("cycles_m1", cyc1, c1);
    checkOutput("divzero_m1", dz1, dz);
    checkOutput("qd_m1", {done1, qd1, qc1, qi1}, 4'b1100);
    if (check_clocks) begin
      checkOutput("compute_clocks_m0", clk0, c0);
      checkOutput("compute_clocks_m1", clk1, c1);
    end
  endtask

  // Ack moves to INITIAL on the next edge; DivZero clears on the first
  // INITIAL clock after that.
  task automatic ackResult();
    Ack = 1'b1;
    @(negedge Clk);
    Ack = 1'b0;
    checkOutput("ack_qi_m0", {qd0, qc0, qi0}, 3'b001);
    checkOutput("ack_qi_m1", {qd1, qc1, qi1}, 3'b001);
    @(negedge Clk);
    checkOutput("ack_divzero_m0", dz0, 0);
    checkOutput("ack_divzero_m1", dz1, 0);
  endtask

  initial begin
    int clk0, clk1, en0;
    int x, y, q, r, c0, c1, dz, sm;

    table_v[0] = '{100, 7, 14, 2, 7, 4, 0};
    table_v[1] = '{255, 1, 255, 0, 128, 4, 0};
    table_v[2] = '{5, 9, 0, 5, 1, 4, 0};
    table_v[3] = '{200, 0, 255, 200, 0, 0, 1};
    table_v[4] = '{0, 3, 0, 0, 1, 4, 0};
    table_v[5] = '{255, 255, 1, 0, 1, 4, 0};
    table_v[6] = '{254, 2, 127, 0, 64, 4, 0};
    table_v[7] = '{14, 7, 2, 0, 1, 4, 0};
    table_v[8] = '{9, 2, 4, 1, 2, 4, 0};

    Reset = 1'b1;
    Xin   = '0;
    Yin   = '0;
    Start = 1'b0;
    Ack   = 1'b0;
    SCEN  = 1'b0;
    repeat (2) @(negedge Clk);
    checkOutput("reset_state_m0", {done0, qd0, qc0, qi0}, 4'b0001);
    checkOutput("reset_state_m1", {done1, qd1, qc1, qi1}, 4'b0001);
    checkOutput("reset_q_m0", q0, 0);
    checkOutput("reset_r_m0", r0, 0);
    checkOutput("reset_cycles_m0", cyc0, 0);
    checkOutput("reset_divzero_m1", dz1, 0);
    Reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(table_v[i].x, table_v[i].y, 0, clk0, clk1, en0);
      checkResult(table_v[i].q, table_v[i].r, table_v[i].cyc0, table_v[i].cyc1,
                  table_v[i].dz, clk0, clk1, 1'b1);
      ackResult();
    end

    // SCEN high one clock in three: same result, 21 clocks spent in COMPUTE.
    applyStimulus(100, 7, 1, clk0, clk1, en0);
    checkOutput("scen_pulse_clocks_m0", clk0, 21);
    checkResult(14, 2, 7, 4, 0, clk0, clk1, 1'b0);
    ackResult();

    // Asynchronous reset between edges in the middle of COMPUTE.
    @(negedge Clk);
    Xin   = 8'd100;
    Yin   = 8'd7;
    Start = 1'b1;
    SCEN  = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (2) @(negedge Clk);
    checkOutput("pre_reset_qc_m0", qc0, 1);
    checkOutput("pre_reset_q_m0", q0, 4);
    #2 Reset = 1'b1;
    #1;
    checkOutput("async_reset_state_m0", {qd0, qc0, qi0}, 3'b001);
    checkOutput("async_reset_q_m0", q0, 0);
    checkOutput("async_reset_cycles_m0", cyc0, 0);
    checkOutput("async_reset_state_m1", {qd1, qc1, qi1}, 3'b001);
    checkOutput("async_reset_cycles_m1", cyc1, 0);
    #1 Reset = 1'b0;

    // Start and Ack together in DONE_S: Ack wins, Start acts from INITIAL.
    applyStimulus(100, 7, 0, clk0, clk1, en0);
    checkResult(14, 2, 7, 4, 0, clk0, clk1, 1'b1);
    Start = 1'b1;
    Ack   = 1'b1;
    @(negedge Clk);
    checkOutput("start_ack_initial_m0", {qd0, qc0, qi0}, 3'b001);
    checkOutput("start_ack_initial_m1", {qd1, qc1, qi1}, 3'b001);
    @(negedge Clk);
    checkOutput("restart_compute_m0", {qd0, qc0, qi0}, 3'b010);
    checkOutput("restart_compute_m1", {qd1, qc1, qi1}, 3'b010);
    Start = 1'b0;
    Ack   = 1'b0;
    runCompute(100, 7, 0, clk0, clk1, en0);
    checkResult(14, 2, 7, 4, 0, clk0, clk1, 1'b1);
    ackResult();

    // Random operands and random SCEN, against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      x  = int'($urandom_range(0, 255));
      y  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4))
                                       : int'($urandom_range(1, 255));
      sm = int'($urandom_range(0, 2));
      model(x, y, q, r, c0, c1, dz);
      applyStimulus(x, y, sm, clk0, clk1, en0);
      checkResult(q, r, c0, c1, dz, clk0, clk1, sm == 0);
      ackResult();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
